// File: rtl/halt_ctrl_if.sv
// Run-control bus between debug/decode sources, halt_ctrl and the PC register.
// master drives requests and debug controls; slave (halt_ctrl) returns run status.
interface halt_ctrl_if #(
  parameter int NUM_SRC = 4,
  parameter int STEP_W  = 8,
  parameter int CNT_W   = 32
);
  logic [NUM_SRC-1:0] halt_req;
  logic [NUM_SRC-1:0] halt_mask;
  logic               go;
  logic               step_mode;
  logic [STEP_W-1:0]  step_n;
  logic               pc_enable;
  logic               halted;
  logic [NUM_SRC-1:0] halt_cause;
  logic [CNT_W-1:0]   halt_cnt;
  logic [CNT_W-1:0]   run_cycles;

  modport master (
    output halt_req, halt_mask, go, step_mode, step_n,
    input  pc_enable, halted, halt_cause, halt_cnt, run_cycles
  );

  modport slave (
    input  halt_req, halt_mask, go, step_mode, step_n,
    output pc_enable, halted, halt_cause, halt_cnt, run_cycles
  );
endinterface

// File: rtl/halt_ctrl.sv
// Run-control FSM gating the PC write enable: maskable halt sources, go/step resume, counters.
// Define HALT_CTRL_RUN_CNT_EN to build the run_cycles counter; otherwise it reads 0.
module halt_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int STEP_W  = 8,
  parameter int CNT_W   = 32
) (
  input  logic      clk,
  input  logic      rst,
  halt_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HALT = 2'd1,
    S_STEP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [STEP_W-1:0]  rem_q, rem_d;
  logic [NUM_SRC-1:0] cause_q, cause_d;
  logic [NUM_SRC-1:0] active;
  logic [CNT_W-1:0]   hcnt_q;
  logic               go_q, go_rise, hit, cnt_inc, pc_en;

  assign active  = bus.halt_req & ~bus.halt_mask;
  assign hit     = |active;
  assign go_rise = bus.go & ~go_q;
  assign pc_en   = (state_q != S_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      rem_q   <= '0;
      cause_q <= '0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cause_q <= cause_d;
      go_q    <= bus.go;
    end
  end

  // hit is only consulted in the enabled states, so go always wins while halted
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cause_d = cause_q;
    cnt_inc = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (hit) begin
          state_d = S_HALT;
          cause_d = active;
          cnt_inc = 1'b1;
        end
      end
      S_HALT: begin
        if (go_rise) begin
          cause_d = '0;
          if (bus.step_mode) begin
            state_d = S_STEP;
            rem_d   = (bus.step_n == '0) ? STEP_W'(1) : bus.step_n;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_STEP: begin
        if (hit) begin
          state_d = S_HALT;
          cause_d = active;
          cnt_inc = 1'b1;
        end else if (rem_q == STEP_W'(1)) begin
          state_d = S_HALT;
          cause_d = '0;
        end else begin
          rem_d = rem_q - STEP_W'(1);
        end
      end
      default: begin
        state_d = S_RUN;
        cause_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     hcnt_q <= '0;
    else if (cnt_inc && ~&hcnt_q) hcnt_q <= hcnt_q + CNT_W'(1);
  end

`ifdef HALT_CTRL_RUN_CNT_EN
  logic [CNT_W-1:0] run_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   run_q <= '0;
    else if (pc_en && ~&run_q) run_q <= run_q + CNT_W'(1);
  end

  assign bus.run_cycles = run_q;
`else
  assign bus.run_cycles = '0;
`endif

  assign bus.pc_enable  = pc_en;
  assign bus.halted     = (state_q == S_HALT);
  assign bus.halt_cause = cause_q;
  assign bus.halt_cnt   = hcnt_q;

endmodule
